// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bank: FSM states, the R/W flag
// position in the address byte, well-known register indices and the default RO mask.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RD,
    WR
  } state_e;

  localparam int RW_BIT = 7;

  localparam int REG_FW_VERSION = 0;
  localparam int REG_FORCE_BT   = 1;

  localparam logic [15:0] DEF_RO_MASK = 16'h0001;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with a registered rising-edge pulse. The pulse is high for one
// clk, starting on the 2nd clk edge after din rises.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic [1:0] sync_q, sync_d;
  logic       pulse_q, pulse_d;

  // sync_q[0] is the newest sample; "01" means it just went high.
  always_comb begin
    sync_d  = {sync_q[0], din};
    pulse_d = (sync_q == 2'b01);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Byte-wide register file behind spi_slave: RO slots return hw_in, RW slots are stored.
// Define SPI_REG_BANK_AUTOINC_EN for burst address auto-increment; otherwise addr stays fixed.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int                      NUM_REGS = 16,
  parameter int                      ADDR_W   = 7,
  parameter logic [NUM_REGS-1:0]     RO_MASK  = NUM_REGS'(DEF_RO_MASK),
  parameter logic [NUM_REGS*8-1:0]   RST_VALS = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  transaction_begin,
  input  logic                  rx_byte_available,
  input  logic [7:0]            rx_byte,
  output logic [7:0]            tx_byte,
  input  logic [NUM_REGS*8-1:0] hw_in,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic [NUM_REGS-1:0]   wr_strobe,
  output logic                  err_pulse
);

  localparam logic [ADDR_W:0] NREGS_C = (ADDR_W+1)'(NUM_REGS);

  function automatic logic [NUM_REGS*8-1:0] masked_rst();
    logic [NUM_REGS*8-1:0] v;
    v = RST_VALS;
    for (int i = 0; i < NUM_REGS; i++)
      if (RO_MASK[i]) v[i*8 +: 8] = 8'h00;
    return v;
  endfunction

  localparam logic [NUM_REGS*8-1:0] RST_REGS = masked_rst();

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NREGS_C;
  endfunction

  function automatic logic is_ro(input logic [ADDR_W-1:0] a);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i)) r = RO_MASK[i];
    return r;
  endfunction

  function automatic logic [7:0] rd_val(input logic [ADDR_W-1:0]   a,
                                        input logic [NUM_REGS*8-1:0] regs,
                                        input logic [NUM_REGS*8-1:0] hw);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i)) v = RO_MASK[i] ? hw[i*8 +: 8] : regs[i*8 +: 8];
    return v;
  endfunction

  // Out-of-range addresses saturate so a bad burst never wraps into valid registers.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_BANK_AUTOINC_EN
    if (!in_range(a)) return a;
    if ({1'b0, a} == (ADDR_W+1)'(NUM_REGS-1)) return '0;
    return a + ADDR_W'(1);
`else
    return a;
`endif
  endfunction

  logic rx_evt;

  sync_edge_det u_rx_edge (
    .clk   (clk),
    .reset (reset),
    .din   (rx_byte_available),
    .pulse (rx_evt)
  );

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [7:0]            tx_q, tx_d;
  logic [NUM_REGS*8-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]   strobe_q, strobe_d;
  logic                  err_q, err_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    tx_d     = tx_q;
    regs_d   = regs_q;
    strobe_d = '0;
    err_d    = 1'b0;
    // A new transaction always wins over a byte landing in the same clk.
    if (transaction_begin) begin
      state_d = ADDR;
      tx_d    = 8'h00;
    end else if (rx_evt) begin
      unique case (state_q)
        ADDR: begin
          addr_d = rx_byte[ADDR_W-1:0];
          if (rx_byte[RW_BIT]) begin
            state_d = WR;
          end else begin
            state_d = RD;
            tx_d    = rd_val(rx_byte[ADDR_W-1:0], regs_q, hw_in);
            err_d   = !in_range(rx_byte[ADDR_W-1:0]);
          end
        end
        RD: begin
          addr_d = next_addr(addr_q);
          tx_d   = rd_val(addr_d, regs_q, hw_in);
          err_d  = !in_range(addr_d);
        end
        WR: begin
          if (in_range(addr_q) && !is_ro(addr_q)) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (addr_q == ADDR_W'(i)) begin
                regs_d[i*8 +: 8] = rx_byte;
                strobe_d[i]      = 1'b1;
              end
          end else begin
            err_d = 1'b1;
          end
          addr_d = next_addr(addr_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      tx_q     <= 8'h00;
      regs_q   <= RST_REGS;
      strobe_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tx_q     <= tx_d;
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign tx_byte   = tx_q;
  assign regs_out  = regs_q;
  assign wr_strobe = strobe_q;
  assign err_pulse = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scenario bench for spi_reg_bank: scripted and random byte streams checked against a
// byte-level model of the register file, plus spot checks of the documented cases.
module tb_spi_reg_bank;

  localparam int               N    = 16;
  localparam logic [N-1:0]     RO   = 16'h0201;
  localparam logic [N*8-1:0]   RSTV = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

  logic           clk = 1'b0;
  logic           reset;
  logic           transaction_begin;
  logic           rx_byte_available;
  logic [7:0]     rx_byte;
  logic [7:0]     tx_byte;
  logic [N*8-1:0] hw_in;
  logic [N*8-1:0] regs_out;
  logic [N-1:0]   wr_strobe;
  logic           err_pulse;

  spi_reg_bank #(.NUM_REGS(N), .ADDR_W(7), .RO_MASK(RO), .RST_VALS(RSTV)) dut (
    .clk               (clk),
    .reset             (reset),
    .transaction_begin (transaction_begin),
    .rx_byte_available (rx_byte_available),
    .rx_byte           (rx_byte),
    .tx_byte           (tx_byte),
    .hw_in             (hw_in),
    .regs_out          (regs_out),
    .wr_strobe         (wr_strobe),
    .err_pulse         (err_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Byte-level reference model: 0 closed, 1 expecting address, 2 reading, 3 writing.
  logic [7:0] m_reg [N];
  int         m_st;
  int         m_addr;
  logic [7:0] m_tx;

  int tot_strb [N];
  int tot_err;

  function automatic logic [7:0] m_rd(input int a);
    if (a >= N) return 8'h00;
    if (RO[a]) return hw_in[a*8 +: 8];
    return m_reg[a];
  endfunction

  function automatic int m_next(input int a);
`ifdef SPI_REG_BANK_AUTOINC_EN
    if (a >= N) return a;
    return (a + 1) % N;
`else
    return a;
`endif
  endfunction

  function automatic logic [N*8-1:0] exp_regs();
    logic [N*8-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (!RO[i]) v[i*8 +: 8] = m_reg[i];
    return v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_addr = 0; m_tx = 8'h00;
    for (int i = 0; i < N; i++) m_reg[i] = RO[i] ? 8'h00 : RSTV[i*8 +: 8];
  endtask

  task automatic model_byte(input logic [7:0] b, input bit co,
                            output logic [N-1:0] es, output bit ee);
    es = '0; ee = 1'b0;
    if (co) begin
      m_st = 1; m_tx = 8'h00;
    end else begin
      case (m_st)
        1: begin
          m_addr = int'(b[6:0]);
          if (b[7]) m_st = 3;
          else begin m_st = 2; m_tx = m_rd(m_addr); ee = (m_addr >= N); end
        end
        2: begin m_addr = m_next(m_addr); m_tx = m_rd(m_addr); ee = (m_addr >= N); end
        3: begin
          if (m_addr < N && !RO[m_addr]) begin m_reg[m_addr] = b; es[m_addr] = 1'b1; end
          else ee = 1'b1;
          m_addr = m_next(m_addr);
        end
        default: ;
      endcase
    end
  endtask

  task automatic pulse_begin();
    transaction_begin = 1'b1;
    @(posedge clk); #1;
    transaction_begin = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic randomize_hw();
    for (int w = 0; w < N / 4; w++) hw_in[w*32 +: 32] = $urandom;
    hw_in[7:0] = 8'hC3;
  endtask

  // Script entries: -1 transaction_begin, -2 reset, bit 8 set = byte coincident with
  // transaction_begin, otherwise a plain byte.
  task automatic run_script(input string nm, input int scr[$]);
    for (int k = 0; k < scr.size(); k++) begin
      int             e;
      bit             co;
      logic [7:0]     o_pre, o_tx, e_pre;
      logic [N-1:0]   o_strb, es;
      int             o_scyc, o_ecyc;
      bit             o_multi, ee;
      e = scr[k];
      if (e == -1) begin
        pulse_begin(); m_st = 1; m_tx = 8'h00;
      end else if (e == -2) begin
        pulse_reset(); model_reset();
      end else begin
        co = e[8];
        rx_byte = e[7:0]; rx_byte_available = 1'b1;
        o_pre = 8'h00; o_tx = 8'h00;
        o_strb = '0; o_scyc = 0; o_ecyc = 0; o_multi = 1'b0;
        for (int i = 0; i < 6; i++) begin
          @(posedge clk); #1;
          if (i == 1) begin o_pre = tx_byte; if (co) transaction_begin = 1'b1; end
          if (i == 2) begin o_tx = tx_byte; transaction_begin = 1'b0; end
          if (|wr_strobe) o_scyc++;
          if (!$onehot0(wr_strobe)) o_multi = 1'b1;
          o_strb |= wr_strobe;
          if (err_pulse) o_ecyc++;
        end
        rx_byte_available = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        e_pre = m_tx;
        model_byte(e[7:0], co, es, ee);
        for (int i = 0; i < N; i++) if (o_strb[i]) tot_strb[i] += o_scyc;
        tot_err += o_ecyc;
        n_cmp++;
        if (o_pre !== e_pre) begin
          n_fail++; $display("FAIL %s[%0d] tx_early: got %h want %h", nm, k, o_pre, e_pre);
        end
        n_cmp++;
        if (o_tx !== m_tx) begin
          n_fail++; $display("FAIL %s[%0d] tx_latency: got %h want %h", nm, k, o_tx, m_tx);
        end
        n_cmp++;
        if (o_strb !== es || o_scyc != int'(es != '0) || o_multi) begin
          n_fail++;
          $display("FAIL %s[%0d] wr_strobe: got %h x%0d multi=%0d want %h", nm, k, o_strb, o_scyc, o_multi, es);
        end
        n_cmp++;
        if (o_ecyc != int'(ee)) begin
          n_fail++; $display("FAIL %s[%0d] err_pulse: got %0d cycles want %0d", nm, k, o_ecyc, ee);
        end
      end
      n_cmp++;
      if (tx_byte !== m_tx) begin
        n_fail++; $display("FAIL %s[%0d] tx_byte: got %h want %h", nm, k, tx_byte, m_tx);
      end
      n_cmp++;
      if (regs_out !== exp_regs()) begin
        n_fail++; $display("FAIL %s[%0d] regs_out: got %h want %h", nm, k, regs_out, exp_regs());
      end
    end
  endtask

  task automatic clr_tot();
    for (int i = 0; i < N; i++) tot_strb[i] = 0;
    tot_err = 0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (tx_byte !== 8'h00 || wr_strobe !== '0 || err_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got tx=%h strb=%h err=%b want 0", tx_byte, wr_strobe, err_pulse);
    end
    n_cmp++;
    if (regs_out !== exp_regs()) begin
      n_fail++; $display("FAIL reset_regs: got %h want %h", regs_out, exp_regs());
    end
  endtask

  task automatic test_read_write();
    clr_tot();
    run_script("rd0", '{-1, 8'h00});
    n_cmp++;
    if (tx_byte !== 8'hC3 || tot_err != 0) begin
      n_fail++; $display("FAIL rd0_value: got %h err=%0d want c3 err=0", tx_byte, tot_err);
    end
    run_script("rd0_dummy", '{8'hFF});
    clr_tot();
    run_script("wr1", '{-1, 8'h81, 8'h01});
    n_cmp++;
    if (regs_out[15:8] !== 8'h01 || tot_strb[1] != 1) begin
      n_fail++; $display("FAIL wr1: got reg1=%h strobes=%0d want 01 x1", regs_out[15:8], tot_strb[1]);
    end
    run_script("rd1", '{-1, 8'h01});
    n_cmp++;
    if (tx_byte !== 8'h01) begin
      n_fail++; $display("FAIL rd1_value: got %h want 01", tx_byte);
    end
  endtask

  task automatic test_burst();
    clr_tot();
    run_script("burst_wr", '{-1, 8'h8E, 8'hAA, 8'hBB, 8'hCC});
`ifdef SPI_REG_BANK_AUTOINC_EN
    n_cmp++;
    if (regs_out[127:112] !== 16'hBBAA || tot_err != 1 || tot_strb[14] != 1 || tot_strb[15] != 1 || tot_strb[0] != 0) begin
      n_fail++; $display("FAIL burst_wr_wrap: got %h err=%0d s14=%0d s15=%0d want bbaa 1 1 1", regs_out[127:112], tot_err, tot_strb[14], tot_strb[15]);
    end
    run_script("burst_rd", '{-1, 8'h0E, 8'hFF, 8'hFF});
    n_cmp++;
    if (tx_byte !== 8'hC3) begin
      n_fail++; $display("FAIL burst_rd_wrap: got %h want c3", tx_byte);
    end
`else
    n_cmp++;
    if (regs_out[119:112] !== 8'hCC || tot_err != 0 || tot_strb[14] != 3) begin
      n_fail++; $display("FAIL burst_wr_fixed: got %h err=%0d s14=%0d want cc 0 3", regs_out[119:112], tot_err, tot_strb[14]);
    end
    run_script("burst_rd", '{-1, 8'h0E, 8'hFF, 8'hFF});
    n_cmp++;
    if (tx_byte !== 8'hCC) begin
      n_fail++; $display("FAIL burst_rd_fixed: got %h want cc", tx_byte);
    end
`endif
  endtask

  task automatic test_out_of_range();
    clr_tot();
    run_script("oor_rd", '{-1, 8'h20, 8'hFF});
    n_cmp++;
    if (tx_byte !== 8'h00 || tot_err != 2) begin
      n_fail++; $display("FAIL oor_rd: got %h err=%0d want 00 2", tx_byte, tot_err);
    end
    clr_tot();
    run_script("oor_wr", '{-1, 8'hA0, 8'h55, -1, 8'h89, 8'h66});
    n_cmp++;
    if (tot_err != 2 || tot_strb[0] != 0 || tot_strb[9] != 0) begin
      n_fail++; $display("FAIL oor_ro_wr: got err=%0d want 2", tot_err);
    end
  endtask

  task automatic test_coincident_and_reset();
    clr_tot();
    run_script("coinc", '{-1, 8'h81, 32'h100 | 8'h85, 8'h03, 8'hFF});
    n_cmp++;
    if (tot_strb[1] != 0 || tot_strb[5] != 0) begin
      n_fail++; $display("FAIL coinc_discard: got s1=%0d s5=%0d want 0 0", tot_strb[1], tot_strb[5]);
    end
    clr_tot();
    run_script("mid_reset", '{-1, 8'h85, 8'h44, -1, 8'h85, -2, 8'h99});
    n_cmp++;
    if (regs_out[47:40] !== 8'hA5 || tx_byte !== 8'h00 || tot_strb[5] != 1) begin
      n_fail++; $display("FAIL mid_reset: got reg5=%h tx=%h s5=%0d want a5 00 1", regs_out[47:40], tx_byte, tot_strb[5]);
    end
  endtask

  task automatic test_addr_mode();
    logic [7:0] r6;
    r6 = m_reg[6];
    clr_tot();
    run_script("mode", '{-1, 8'h85, 8'h11, 8'h22});
`ifdef SPI_REG_BANK_AUTOINC_EN
    n_cmp++;
    if (regs_out[55:40] !== 16'h2211 || tot_strb[5] != 1 || tot_strb[6] != 1) begin
      n_fail++; $display("FAIL autoinc: got %h s5=%0d s6=%0d want 2211 1 1", regs_out[55:40], tot_strb[5], tot_strb[6]);
    end
`else
    n_cmp++;
    if (regs_out[47:40] !== 8'h22 || regs_out[55:48] !== r6 || tot_strb[5] != 2 || tot_strb[6] != 0) begin
      n_fail++; $display("FAIL fixed_addr: got r5=%h r6=%h s5=%0d want 22 %h 2", regs_out[47:40], regs_out[55:48], tot_strb[5], r6);
    end
`endif
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int scr[$];
      int nb, x, r;
      randomize_hw();
      scr.push_back(-1);
      scr.push_back(int'($urandom_range(0, 1) << 7) | int'($urandom_range(0, 19)));
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb; j++) begin
        x = $urandom_range(0, 255);
        r = $urandom_range(0, 19);
        if (r == 0) x |= 256;
        if (r == 1) scr.push_back(-2);
        scr.push_back(x);
      end
      run_script("random", scr);
    end
  endtask

  initial begin
    reset = 1'b1;
    transaction_begin = 1'b0;
    rx_byte_available = 1'b0;
    rx_byte = 8'h00;
    hw_in = '0;
    randomize_hw();
    model_reset();
    clr_tot();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_write();
    test_burst();
    test_out_of_range();
    test_coincident_and_reset();
    test_addr_mode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
